// File: rtl/lab_pkg.sv
// Constants and helpers shared by the L*a*b* composition stage.
package lab_pkg;

  localparam int FRAC_DEF = 11;

  localparam int K_L   = 116;
  localparam int L_OFF = 16;
  localparam int K_A   = 500;
  localparam int K_B   = 200;

  localparam int L_MAX  = 100;
  localparam int AB_MIN = -128;
  localparam int AB_MAX = 127;

  typedef enum int {
    CH_L = 0,
    CH_A = 1,
    CH_B = 2
  } chan_e;

  // Constant multiply as a sum of shifted copies, so it maps onto adders.
  function automatic logic signed [31:0] mul_const(input logic signed [31:0] x,
                                                   input logic [15:0] k);
    logic signed [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) acc = acc + (x <<< i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/lab_round_clamp.sv
// Round-half-up a signed fixed-point product to an integer, then clamp it to
// [LO, HI] and report whether the clamp engaged. Purely combinational.
module lab_round_clamp #(
  parameter int P_W  = 23,
  parameter int FRAC = 11,
  parameter int LO   = 0,
  parameter int HI   = 100
) (
  input  logic signed [P_W-1:0] p,
  output logic        [7:0]     q,
  output logic                  sat
);

  localparam logic signed [P_W:0] HALF = (P_W + 1)'(1) <<< (FRAC - 1);
  localparam logic signed [P_W:0] LO_W = (P_W + 1)'(LO);
  localparam logic signed [P_W:0] HI_W = (P_W + 1)'(HI);

  logic signed [P_W:0] biased;
  logic signed [P_W:0] r;

  always_comb begin
    biased = $signed({p[P_W-1], p}) + HALF;
    r      = biased >>> FRAC;
    if (r < LO_W) begin
      q   = LO_W[7:0];
      sat = 1'b1;
    end else if (r > HI_W) begin
      q   = HI_W[7:0];
      sat = 1'b1;
    end else begin
      q   = r[7:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/lab_compose.sv
// Combines the fx/fy/fz transform streams into rounded, clamped 8-bit L*a*b*
// with a 3-cycle pipeline, matched sideband delay and per-frame clamp count.
module lab_compose
  import lab_pkg::*;
#(
  parameter int DSIZE = 12,
  parameter int FRAC  = FRAC_DEF,
  parameter int SB_W  = 3,
  parameter int CNT_W = 20
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cal_valid,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] fx,
  input  logic [DSIZE-1:0] fy,
  input  logic [DSIZE-1:0] fz,
  input  logic [SB_W-1:0]  in_sb,
  input  logic             frame_end,
  output logic             out_valid,
  output logic [7:0]       l_out,
  output logic [7:0]       a_out,
  output logic [7:0]       b_out,
  output logic [SB_W-1:0]  out_sb,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_count
);

  localparam int P_W = DSIZE + 11;

  logic acc;
  assign acc = in_valid & cal_valid;

  // S1: differences
  logic                    v1_reg;
  logic                    fe1_reg;
  logic [DSIZE-1:0]        fy1_reg;
  logic signed [DSIZE:0]   dxy1_reg;
  logic signed [DSIZE:0]   dyz1_reg;

  // S2: products
  logic                    v2_reg;
  logic                    fe2_reg;
  logic signed [P_W-1:0]   p2_reg [3];
  logic signed [P_W-1:0]   p_next [3];
  logic signed [31:0]      fy_w;
  logic signed [31:0]      dxy_w;
  logic signed [31:0]      dyz_w;

  // S3 / output
  logic                    fe3_reg;
  logic [7:0]              q3 [3];
  logic [2:0]              sat3;
  logic [SB_W-1:0]         sb_pipe_reg [2];
  logic [CNT_W-1:0]        run_cnt_reg;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      fe1_reg  <= 1'b0;
      fy1_reg  <= '0;
      dxy1_reg <= '0;
      dyz1_reg <= '0;
    end else begin
      v1_reg   <= acc;
      fe1_reg  <= acc & frame_end;
      fy1_reg  <= fy;
      dxy1_reg <= $signed({1'b0, fx}) - $signed({1'b0, fy});
      dyz1_reg <= $signed({1'b0, fy}) - $signed({1'b0, fz});
    end
  end

  always_comb begin
    fy_w         = 32'(signed'({1'b0, fy1_reg}));
    dxy_w        = 32'(dxy1_reg);
    dyz_w        = 32'(dyz1_reg);
    p_next[CH_L] = P_W'(mul_const(fy_w, 16'(K_L)) - (L_OFF <<< FRAC));
    p_next[CH_A] = P_W'(mul_const(dxy_w, 16'(K_A)));
    p_next[CH_B] = P_W'(mul_const(dyz_w, 16'(K_B)));
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      v2_reg  <= 1'b0;
      fe2_reg <= 1'b0;
      for (int i = 0; i < 3; i++) p2_reg[i] <= '0;
    end else begin
      v2_reg  <= v1_reg;
      fe2_reg <= fe1_reg;
      for (int i = 0; i < 3; i++) p2_reg[i] <= p_next[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rc
      localparam int LO = (gi == int'(CH_L)) ? 0     : AB_MIN;
      localparam int HI = (gi == int'(CH_L)) ? L_MAX : AB_MAX;
      lab_round_clamp #(
        .P_W  (P_W),
        .FRAC (FRAC),
        .LO   (LO),
        .HI   (HI)
      ) u_rc (
        .p   (p2_reg[gi]),
        .q   (q3[gi]),
        .sat (sat3[gi])
      );
    end
  endgenerate

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      fe3_reg   <= 1'b0;
      l_out     <= '0;
      a_out     <= '0;
      b_out     <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= v2_reg;
      fe3_reg   <= fe2_reg;
      l_out     <= q3[CH_L];
      a_out     <= q3[CH_A];
      b_out     <= q3[CH_B];
      sat_flag  <= v2_reg & (|sat3);
    end
  end

  // Sideband runs every cycle, regardless of acceptance, to stay aligned.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sb_pipe_reg[0] <= '0;
      sb_pipe_reg[1] <= '0;
      out_sb         <= '0;
    end else begin
      sb_pipe_reg[0] <= in_sb;
      sb_pipe_reg[1] <= sb_pipe_reg[0];
      out_sb         <= sb_pipe_reg[1];
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      run_cnt_reg <= '0;
      sat_count   <= '0;
    end else if (out_valid && fe3_reg) begin
      sat_count   <= (run_cnt_reg == '1) ? '1 : run_cnt_reg + CNT_W'(sat_flag);
      run_cnt_reg <= '0;
    end else if (out_valid && sat_flag && run_cnt_reg != '1) begin
      run_cnt_reg <= run_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lab_compose.sv
// Scoreboard bench for lab_compose: driver pushes reference results computed
// from the L*a*b* formulas; a negedge monitor pops and compares on out_valid.
module tb_lab_compose;

  localparam int DSIZE = 12;
  localparam int FRAC  = 11;
  localparam int SB_W  = 3;
  localparam int CNT_W = 4;
  localparam int ONE   = 1 << FRAC;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int FMAX  = (1 << DSIZE) - 1;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic             cal_valid = 1'b0;
  logic             in_valid = 1'b0;
  logic [DSIZE-1:0] fx = '0;
  logic [DSIZE-1:0] fy = '0;
  logic [DSIZE-1:0] fz = '0;
  logic [SB_W-1:0]  in_sb = '0;
  logic             frame_end = 1'b0;
  logic             out_valid;
  logic [7:0]       l_out;
  logic [7:0]       a_out;
  logic [7:0]       b_out;
  logic [SB_W-1:0]  out_sb;
  logic             sat_flag;
  logic [CNT_W-1:0] sat_count;

  lab_compose #(
    .DSIZE (DSIZE),
    .FRAC  (FRAC),
    .SB_W  (SB_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .cal_valid (cal_valid),
    .in_valid  (in_valid),
    .fx        (fx),
    .fy        (fy),
    .fz        (fz),
    .in_sb     (in_sb),
    .frame_end (frame_end),
    .out_valid (out_valid),
    .l_out     (l_out),
    .a_out     (a_out),
    .b_out     (b_out),
    .out_sb    (out_sb),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int l;
    int a;
    int b;
    int sb;
    bit sat;
    bit fe;
    int cnt;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_sat_count = 0;
  int   run_model = 0;
  int   txn = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
    end
  endtask

  // floor(p / 2^FRAC + 0.5)
  function automatic int fl_round(input int p);
    int n;
    n = p + ONE / 2;
    return (n >= 0) ? n / ONE : -((-n + ONE - 1) / ONE);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int near(input int c);
    return clampi(c + int'($urandom_range(0, 400)) - 200, 0, FMAX);
  endfunction

  task automatic model_push(input int x, input int y, input int z,
                            input int sb, input bit fe);
    exp_t e;
    int lr, ar, br;
    lr = fl_round(116 * y - 16 * ONE);
    ar = fl_round(500 * (x - y));
    br = fl_round(200 * (y - z));
    e.l   = clampi(lr, 0, 100);
    e.a   = clampi(ar, -128, 127);
    e.b   = clampi(br, -128, 127);
    e.sat = (e.l != lr) || (e.a != ar) || (e.b != br);
    e.sb  = sb;
    e.fe  = fe;
    e.cyc = cyc + 3;
    if (fe) begin
      e.cnt     = (run_model + int'(e.sat) > CMAX) ? CMAX : run_model + int'(e.sat);
      run_model = 0;
    end else begin
      e.cnt = 0;
      if (e.sat && run_model < CMAX) run_model++;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit v, input bit cv, input int x, input int y,
                       input int z, input bit fe);
    @(posedge clock);
    #1;
    in_valid  = v;
    cal_valid = cv;
    fx        = DSIZE'(x);
    fy        = DSIZE'(y);
    fz        = DSIZE'(z);
    frame_end = fe;
    in_sb     = SB_W'($urandom);
    if (v && cv) model_push(x, y, z, int'(in_sb), fe);
  endtask

  task automatic drive_random();
    int y, x, z;
    y = int'($urandom_range(0, FMAX));
    x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FMAX)) : near(y);
    z = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FMAX)) : near(y);
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, x, y, z,
          $urandom_range(0, 7) == 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_l_out"}, int'(l_out), 0);
    chk({tag, "_a_out"}, int'(a_out), 0);
    chk({tag, "_b_out"}, int'(b_out), 0);
    chk({tag, "_out_sb"}, int'(out_sb), 0);
    chk({tag, "_sat_flag"}, int'(sat_flag), 0);
    chk({tag, "_sat_count"}, int'(sat_count), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!rst) begin
        chk("sat_count", int'(sat_count), exp_sat_count);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", int'(out_valid), 0);
          end else begin
            e = exp_q.pop_front();
            chk("l_out", int'(l_out), e.l);
            chk("a_out", int'($signed(a_out)), e.a);
            chk("b_out", int'($signed(b_out)), e.b);
            chk("out_sb", int'(out_sb), e.sb);
            chk("sat_flag", int'(sat_flag), int'(e.sat));
            chk("latency", cyc, e.cyc);
            if (e.fe) exp_sat_count = e.cnt;
            txn++;
            $display("txn %0d L=%0d a=%0d b=%0d sb=%0d sat=%0d fe=%0d", txn,
                     l_out, $signed(a_out), $signed(b_out), out_sb, sat_flag, e.fe);
          end
        end else begin
          chk("sat_flag_idle", int'(sat_flag), 0);
        end
      end
    end
  end

  initial begin : stim
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero_outputs("reset");
    @(posedge clock);
    #2 rst = 1'b0;

    // Reference points; the fourth closes a frame holding two clamps.
    drive(1, 1, 2048, 2048, 2048, 0);
    drive(1, 1, 1024, 1034, 1034, 0);
    drive(1, 1, 2048, 1024, 1024, 0);
    drive(1, 1, 0, 0, 0, 1);

    // 10-pixel frame, clamps at 2, 5, 9; the last one ends the frame.
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 9) drive(1, 1, 2048, 1024, 1024, i == 9);
      else                            drive(1, 1, 2048, 2048, 2048, 0);
    end

    // Back-to-back frame ends.
    drive(1, 1, 0, 0, 0, 1);
    drive(1, 1, 2048, 2048, 2048, 1);

    // Frame end on a dropped pixel is ignored.
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 2048, 2048, 2048, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 2048, 2048, 2048, 1);

    // Running counter saturates rather than wrapping.
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 0, i == 19);
    drive(1, 1, 2048, 2048, 2048, 1);

    // cal_valid toggling with in_valid held high.
    for (int i = 0; i < 12; i++) drive(1, (i % 2) == 0, near(2048), 2048, near(2048), i == 11);

    repeat (250) drive_random();

    // Asynchronous reset mid-stream.
    repeat (20) drive(1, 1, near(1500), 1500, near(1500), 0);
    @(posedge clock);
    #2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    cal_valid = 1'b0;
    #1;
    check_zero_outputs("midrst");
    exp_q.delete();
    run_model     = 0;
    exp_sat_count = 0;
    repeat (2) @(posedge clock);
    #2 rst = 1'b0;

    repeat (150) drive_random();

    repeat (6) drive(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab_compose.md
Name: lab_compose

Overview:
- Downstream stage of the three piecewise-linear f(t) transform instances (fx, fy, fz) in the rgb-lab path.
- Combines the three f() streams into CIE L*, a*, b*: L = 116·fy − 16, a = 500·(fx − fy), b = 200·(fy − fz).
- Produces rounded, clamped 8-bit L/a/b with matched sideband timing and a per-frame saturation count.
- Fully pipelined, one pixel per clock, no backpressure (valid-only stream as elsewhere in the path).

Parameters:
- DSIZE, 12, width of each f() input (unsigned fixed point, same as the transform outdata width).
- FRAC, 11, fractional bits of f() inputs (1.0 = 2^FRAC).
- SB_W, 3, sideband width (e.g. vsync/href/de) delayed alongside data.
- CNT_W, 20, saturation counter width.

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cal_valid  in  1  high when all three upstream transforms have finished their delta calculation; gates acceptance.
- in_valid  in  1  fx/fy/fz/in_sb/frame_end qualify this cycle.
- fx  in  DSIZE  f(X/Xn).
- fy  in  DSIZE  f(Y/Yn).
- fz  in  DSIZE  f(Z/Zn).
- in_sb  in  SB_W  sideband, delayed with the data.
- frame_end  in  1  marks the last pixel of a frame (meaningful only with in_valid).
- out_valid  out  1  L/a/b valid.
- l_out  out  8  L, unsigned, clamped 0..100.
- a_out  out  8  a, two's complement, clamped −128..127.
- b_out  out  8  b, two's complement, clamped −128..127.
- out_sb  out  SB_W  delayed sideband.
- sat_flag  out  1  current output pixel had at least one channel clamped.
- sat_count  out  CNT_W  clamped-pixel count of the last completed frame.

Behaviour:
- Accept condition: acc = in_valid & cal_valid. Pixels presented while cal_valid = 0 are dropped; pixels already in flight still drain.
- Latency: fixed 3 cycles from acc to out_valid.
  - out_sb and the delayed frame_end follow the same 3-stage delay.
  - Sideband is delayed unconditionally, every cycle, independent of acc.
- S1 stage:
  - register fy;
  - dxy = fx − fy and dyz = fy − fz, each signed DSIZE+1 bits.
- S2 stage: products in signed DSIZE+11 bits, computed by shift-add (no DSP required).
  - pL = 116·fy − (16 << FRAC)
  - pA = 500·dxy
  - pB = 200·dyz
- S3 stage:
  - Rounding: r = (p + 2^(FRAC−1)) >>> FRAC (arithmetic shift, i.e. floor(x + 0.5)).
  - Clamping: L to [0,100]; a and b to [−128,127].
  - sat_flag = any clamp active, qualified by out_valid.
- Reset values: out_valid, l_out, a_out, b_out, out_sb, sat_flag, sat_count and all pipeline registers are 0.
  - Reset mid-frame discards in-flight pixels and zeroes the running counter.
- Running counter:
  - increments on out_valid & sat_flag;
  - holds at all-ones rather than wrapping.
- Frame end (cycle where the delayed frame_end & out_valid):
  - sat_count ← running counter + current pixel's sat_flag, saturated;
  - the running counter clears to 0 in the same cycle.
- Frame-end corner cases:
  - back-to-back frame_end pixels each latch their own count (1 or 0);
  - frame_end on a dropped pixel (cal_valid = 0) has no effect;
  - sat_count holds its value between frame ends.
- cal_valid falling mid-stream: no flush; the output simply shows gaps.

Decomposition:
- Package lab_pkg holds:
  - constants K_L = 116, L_OFF = 16, K_A = 500, K_B = 200;
  - clamp limits L_MAX = 100, AB_MIN = −128, AB_MAX = 127;
  - the default FRAC.
- Sub-module lab_round_clamp: takes a signed product, FRAC, lo and hi limits; outputs the rounded, clamped 8-bit value plus a sat bit. It is combinational and is instantiated three times in S3.

Test Plan:
- fx = fy = fz = 2048 with cal_valid = 1 → 3 cycles later: l_out = 100, a_out = 0, b_out = 0, sat_flag = 0.
- fx = 1024, fy = 1034, fz = 1034 → l_out = 43, a_out = 0xFE (−2), b_out = 0, sat_flag = 0 (checks signed rounding).
- fx = 2048, fy = 1024, fz = 1024 → l_out = 42, a_out = 127 (clamped from 250), b_out = 0, sat_flag = 1.
- fy = 0, fx = fz = 0 → l_out = 0 (clamped from −16), sat_flag = 1.
  - 10-pixel frame with 3 saturating pixels, the last of which carries frame_end → sat_count = 3 one cycle after that pixel's out_valid; the running counter restarts at 0.
- Stream with in_valid = 1 while cal_valid toggles 1/0 → only accepted pixels appear, out_sb stays aligned with them. Assert rst mid-stream → all outputs 0 immediately, no stale pixel emerges after release.
